sram_burst_reader: RTL and testbench



---
 rtl/sram_burst_reader.sv | 210 +++++++++++++++++++++
 tb/tb_sram_burst_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_reader.sv
// sram_burst_reader: reads a burst of consecutive SRAM words and streams them out in address order.
// Latency: start sampled at edge 0, first sram_select in the following cycle, first data_valid after edge 2.
// Backpressure: reads are issued only while the FIFO has room for them, so data is never dropped while data_ack is low.
//
// Ports:
//   sram_clock, reset_n                 clock shared with the SRAM; asynchronous active-low reset
//   start, start_address, length        command strobe, first word address, word count (0 is legal)
//   busy, done                          burst in progress; one-cycle completion pulse
//   sram_address, sram_read_not_write,  registered read port towards the SRAM (read_not_write is
//   sram_select, sram_data_out          tied high); sram_data_out is valid the cycle after select
//   data_valid, data, data_ack          output stream; data is the FIFO head
//   checksum                            XOR of the words acked in the current burst (optional)
//
// Optional feature: define SRAM_BURST_READER_CHECKSUM_EN to add the checksum output.

// sram_burst_reader_fifo: small FIFO for the read data.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: none internally; the caller keeps push away from a full FIFO unless it also pops.
module sram_burst_reader_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     pop,
  output logic [width-1:0]         head,
  output logic                     not_empty,
  output logic [$clog2(depth):0]   count
);
  localparam int PW = $clog2(depth);

  logic [width-1:0] storage [depth];
  logic [PW-1:0]    write_pointer;
  logic [PW-1:0]    read_pointer;
  logic             do_pop;

  // A pop on an empty FIFO is a no-op.
  assign do_pop    = pop && not_empty;
  assign not_empty = (count != '0);
  assign head      = storage[read_pointer];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
    end else begin
      if (push)   write_pointer <= write_pointer + 1'b1;
      if (do_pop) read_pointer  <= read_pointer + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset; count gates visibility of stale entries.
  always_ff @(posedge clock) begin
    if (push) storage[write_pointer] <= push_data;
  end

  overflow_check: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !do_pop && (count == (PW+1)'(depth))));

endmodule

module sram_burst_reader #(
  parameter int address_width = 16,
  parameter int data_width    = 8,
  parameter int fifo_depth    = 4
) (
  input  logic                     sram_clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [address_width-1:0] start_address,
  input  logic [address_width:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [address_width-1:0] sram_address,
  output logic                     sram_read_not_write,
  output logic                     sram_select,
  input  logic [data_width-1:0]    sram_data_out,
  output logic                     data_valid,
  output logic [data_width-1:0]    data,
  input  logic                     data_ack
`ifdef SRAM_BURST_READER_CHECKSUM_EN
  ,
  output logic [data_width-1:0]    checksum
`endif
);
  localparam int CW = $clog2(fifo_depth) + 1;
  // Wide enough for fifo_count + pending without overflow.
  localparam int UW = CW + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                   state;
  logic [address_width-1:0] address;    // next address to issue
  logic [address_width:0]   remaining;  // words not yet issued
  logic [1:0]               pending;    // issued but not yet written into the FIFO
  logic                     capture;    // SRAM output holds a requested word this cycle
  logic [CW-1:0]            fifo_count;
  logic                     pop;
  logic [UW-1:0]            credit_used;
  logic                     run_issue;
  logic                     start_issue;
  logic                     issue_now;
  logic                     drained;

  assign sram_read_not_write = 1'b1;
  assign pop = data_valid && data_ack;

  // Slots already claimed once this cycle's ack is taken into account.
  assign credit_used = UW'(fifo_count) + UW'(pending) - UW'(pop);
  assign run_issue   = (state == RUN) && (remaining != '0) && (credit_used < UW'(fifo_depth));
  // The first read goes out on the start edge itself, so the FIFO
  // sees data two edges after start. The FIFO is empty in IDLE.
  assign start_issue = (state == IDLE) && start && (length != '0);
  assign issue_now   = start_issue || run_issue;
  // With pending==0 no FIFO write can happen this cycle, so an ack
  // of the last entry leaves the FIFO empty.
  assign drained     = (remaining == '0) && (pending == 2'd0) && (fifo_count == CW'(pop));

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      sram_select  <= 1'b0;
      sram_address <= '0;
      address      <= '0;
      remaining    <= '0;
      pending      <= 2'd0;
      capture      <= 1'b0;
    end else begin
      done        <= 1'b0;
      sram_select <= issue_now;
      capture     <= sram_select;
      pending     <= pending + 2'(issue_now) - 2'(capture);
      if (issue_now) sram_address <= (state == IDLE) ? start_address : address;

      unique case (state)
        IDLE: begin
          if (start) begin
            address   <= start_address + address_width'(start_issue);
            remaining <= length - (address_width+1)'(start_issue);
            if (length == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (run_issue) begin
            address   <= address + 1'b1;
            remaining <= remaining - 1'b1;
          end
          if (drained) begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FINISH: begin
          // start here is deliberately dropped; a new command is taken from IDLE.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sram_burst_reader_fifo #(
    .width (data_width),
    .depth (fifo_depth)
  ) output_fifo (
    .clock     (sram_clock),
    .reset_n   (reset_n),
    .push      (capture),
    .push_data (sram_data_out),
    .pop       (pop),
    .head      (data),
    .not_empty (data_valid),
    .count     (fifo_count)
  );

`ifdef SRAM_BURST_READER_CHECKSUM_EN
  // Cleared by an accepted start; no data is valid outside a burst, so
  // the value holds from done until the next accepted start.
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum ^ data;
    end
  end
`endif

endmodule

// File: tb/tb_sram_burst_reader.sv
module tb_sram_burst_reader;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          sram_clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_address;
  logic [AW:0]   length;
  logic          busy, done, sram_read_not_write, sram_select, data_valid, data_ack;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_data_out = '0;
  logic [DW-1:0] data;
`ifdef SRAM_BURST_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] mem [0:65535];

  always #5 sram_clock = ~sram_clock;

  // Registered-read SRAM model.
  always @(posedge sram_clock) begin
    if (sram_select) sram_data_out <= mem[sram_address];
  end

  sram_burst_reader dut (
    .sram_clock          (sram_clock),
    .reset_n             (reset_n),
    .start               (start),
    .start_address       (start_address),
    .length              (length),
    .busy                (busy),
    .done                (done),
    .sram_address        (sram_address),
    .sram_read_not_write (sram_read_not_write),
    .sram_select         (sram_select),
    .sram_data_out       (sram_data_out),
    .data_valid          (data_valid),
    .data                (data),
    .data_ack            (data_ack)
`ifdef SRAM_BURST_READER_CHECKSUM_EN
    ,
    .checksum            (checksum)
`endif
  );

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; start_address = '0; length = '0; data_ack = 1'b0;
    repeat (2) @(negedge sram_clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (sram_select !== 1'b0) begin failures++; $display("FAIL reset_select got=%0b exp=0", sram_select); end
    checks++; if (sram_address !== 16'h0000) begin failures++; $display("FAIL reset_address got=%0h exp=0", sram_address); end
    checks++; if (sram_read_not_write !== 1'b1) begin failures++; $display("FAIL reset_rnw got=%0b exp=1", sram_read_not_write); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", data_valid); end
`ifdef SRAM_BURST_READER_CHECKSUM_EN
    checks++; if (checksum !== 8'h00) begin failures++; $display("FAIL reset_checksum got=%0h exp=0", checksum); end
`endif
    reset_n = 1'b1;
    @(negedge sram_clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_basic();
    logic          es, ev, eb, ed;
    logic [AW-1:0] ea;
    @(negedge sram_clock);
    start = 1'b1; start_address = 16'h0010; length = 17'd8; data_ack = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge sram_clock);
      if (c == 0) start = 1'b0;
      es = (c <= 7); ev = (c >= 2 && c <= 9); eb = (c <= 9); ed = (c == 10);
      ea = 16'h0010 + 16'(c);
      checks++; if (sram_select !== es) begin failures++; $display("FAIL basic_select c=%0d got=%0b exp=%0b", c, sram_select, es); end
      if (es) begin
        checks++; if (sram_address !== ea) begin failures++; $display("FAIL basic_address c=%0d got=%0h exp=%0h", c, sram_address, ea); end
      end
      checks++; if (data_valid !== ev) begin failures++; $display("FAIL basic_valid c=%0d got=%0b exp=%0b", c, data_valid, ev); end
      if (ev) begin
        checks++; if (data !== 8'(c + 14)) begin failures++; $display("FAIL basic_data c=%0d got=%0h exp=%0h", c, data, 8'(c + 14)); end
      end
      checks++; if (busy !== eb) begin failures++; $display("FAIL basic_busy c=%0d got=%0b exp=%0b", c, busy, eb); end
      checks++; if (done !== ed) begin failures++; $display("FAIL basic_done c=%0d got=%0b exp=%0b", c, done, ed); end
      if (c == 0) begin
        checks++; if (sram_read_not_write !== 1'b1) begin failures++; $display("FAIL basic_rnw got=%0b exp=1", sram_read_not_write); end
      end
    end
  endtask

  task automatic test_zero_length();
    @(negedge sram_clock);
    start = 1'b1; start_address = 16'h0050; length = 17'd0; data_ack = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      @(negedge sram_clock);
      if (c == 0) start = 1'b0;
      checks++; if (done !== (c == 0)) begin failures++; $display("FAIL zero_done c=%0d got=%0b exp=%0b", c, done, (c == 0)); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy c=%0d got=%0b exp=0", c, busy); end
      checks++; if (sram_select !== 1'b0) begin failures++; $display("FAIL zero_select c=%0d got=%0b exp=0", c, sram_select); end
      checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL zero_valid c=%0d got=%0b exp=0", c, data_valid); end
    end
  endtask

  task automatic test_backpressure();
    int n = 0, issued = 0, max_out = 0, low_phase_issues = 0;
    bit seen_done = 0;
    @(negedge sram_clock);
    start = 1'b1; start_address = 16'h0020; length = 17'd16; data_ack = 1'b0;
    for (int c = 0; c < 80 && !seen_done; c++) begin
      @(negedge sram_clock);
      if (c == 0) start = 1'b0;
      data_ack = (c >= 10);
      if (sram_select) issued++;
      if (sram_select && c < 10) low_phase_issues++;
      // Issued-but-unaccepted words equal fifo_count + pending.
      if (issued - n > max_out) max_out = issued - n;
      if (data_valid && data_ack) begin
        checks++; if (data !== 8'(32 + n)) begin failures++; $display("FAIL bp_data n=%0d got=%0h exp=%0h", n, data, 8'(32 + n)); end
        n++;
      end
      if (done) seen_done = 1;
    end
    checks++; if (!seen_done) begin failures++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    checks++; if (low_phase_issues != 4) begin failures++; $display("FAIL bp_issues_while_stalled got=%0d exp=4", low_phase_issues); end
    checks++; if (max_out != 4) begin failures++; $display("FAIL bp_max_outstanding got=%0d exp=4", max_out); end
    checks++; if (issued != 16) begin failures++; $display("FAIL bp_issued got=%0d exp=16", issued); end
    checks++; if (n != 16) begin failures++; $display("FAIL bp_words got=%0d exp=16", n); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_after_done got=%0b exp=0", data_valid); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea;
    @(negedge sram_clock);
    start = 1'b1; start_address = 16'hFFFE; length = 17'd4; data_ack = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      @(negedge sram_clock);
      if (c == 0) start = 1'b0;
      ea = 16'hFFFE + 16'(c);
      checks++; if (sram_select !== (c <= 3)) begin failures++; $display("FAIL wrap_select c=%0d got=%0b exp=%0b", c, sram_select, (c <= 3)); end
      if (c <= 3) begin
        checks++; if (sram_address !== ea) begin failures++; $display("FAIL wrap_address c=%0d got=%0h exp=%0h", c, sram_address, ea); end
      end
      if (c >= 2 && c <= 5) begin
        ea = 16'hFFFE + 16'(c - 2);
        checks++; if (data !== ea[7:0]) begin failures++; $display("FAIL wrap_data c=%0d got=%0h exp=%0h", c, data, ea[7:0]); end
      end
      checks++; if (done !== (c == 6)) begin failures++; $display("FAIL wrap_done c=%0d got=%0b exp=%0b", c, done, (c == 6)); end
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge sram_clock);
    start = 1'b1; start_address = 16'h0030; length = 17'd8; data_ack = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge sram_clock);
      if (c == 0) start = 1'b0;
      if (c >= 2) begin
        checks++; if (data !== 8'(46 + c)) begin failures++; $display("FAIL rst_pre_data c=%0d got=%0h exp=%0h", c, data, 8'(46 + c)); end
      end
    end
    @(negedge sram_clock);
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (sram_select !== 1'b0) begin failures++; $display("FAIL rst_select got=%0b exp=0", sram_select); end
    checks++; if (sram_address !== 16'h0000) begin failures++; $display("FAIL rst_address got=%0h exp=0", sram_address); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", data_valid); end
    for (int c = 0; c < 2; c++) begin
      @(negedge sram_clock);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done c=%0d got=%0b exp=0", c, done); end
    end
    reset_n = 1'b1;
    @(negedge sram_clock);
    start = 1'b1; start_address = 16'h0000; length = 17'd2;
    for (int c = 0; c <= 5; c++) begin
      @(negedge sram_clock);
      if (c == 0) start = 1'b0;
      checks++; if (data_valid !== (c == 2 || c == 3)) begin failures++; $display("FAIL rst_after_valid c=%0d got=%0b exp=%0b", c, data_valid, (c == 2 || c == 3)); end
      if (c == 2 || c == 3) begin
        checks++; if (data !== 8'(c - 2)) begin failures++; $display("FAIL rst_after_data c=%0d got=%0h exp=%0h", c, data, 8'(c - 2)); end
      end
      checks++; if (busy !== (c <= 3)) begin failures++; $display("FAIL rst_after_busy c=%0d got=%0b exp=%0b", c, busy, (c <= 3)); end
      checks++; if (done !== (c == 4)) begin failures++; $display("FAIL rst_after_done c=%0d got=%0b exp=%0b", c, done, (c == 4)); end
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] exp_w [4];
    exp_w[0] = 8'h01; exp_w[1] = 8'h02; exp_w[2] = 8'h04; exp_w[3] = 8'h80;
    @(negedge sram_clock);
    start = 1'b1; start_address = 16'h0100; length = 17'd4; data_ack = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      @(negedge sram_clock);
      start = 1'b0;
      if (c == 1) begin start = 1'b1; start_address = 16'h0000; length = 17'd8; end
      if (c == 6) begin start = 1'b1; start_address = 16'h0000; length = 17'd8; end
      checks++; if (sram_select !== (c <= 3)) begin failures++; $display("FAIL ign_select c=%0d got=%0b exp=%0b", c, sram_select, (c <= 3)); end
      if (c <= 3) begin
        checks++; if (sram_address !== 16'h0100 + 16'(c)) begin failures++; $display("FAIL ign_address c=%0d got=%0h exp=%0h", c, sram_address, 16'h0100 + 16'(c)); end
      end
      if (c >= 2 && c <= 5) begin
        checks++; if (data !== exp_w[c-2]) begin failures++; $display("FAIL ign_data c=%0d got=%0h exp=%0h", c, data, exp_w[c-2]); end
      end
      checks++; if (busy !== (c <= 5)) begin failures++; $display("FAIL ign_busy c=%0d got=%0b exp=%0b", c, busy, (c <= 5)); end
      checks++; if (done !== (c == 6)) begin failures++; $display("FAIL ign_done c=%0d got=%0b exp=%0b", c, done, (c == 6)); end
`ifdef SRAM_BURST_READER_CHECKSUM_EN
      if (c == 0) begin
        checks++; if (checksum !== 8'h00) begin failures++; $display("FAIL ign_checksum_clear got=%0h exp=0", checksum); end
      end
      if (c >= 6) begin
        checks++; if (checksum !== 8'h87) begin failures++; $display("FAIL ign_checksum c=%0d got=%0h exp=87", c, checksum); end
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h02; mem[16'h0102] = 8'h04; mem[16'h0103] = 8'h80;
    test_reset();
    test_basic();
    test_zero_length();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
